// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation classes, immediate
// formats and the control-bit bundle carried from ID into EX.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_R   = 3'b000,
    ALU_I   = 3'b001,
    ALU_ADD = 3'b010,
    ALU_BR  = 3'b011,
    ALU_LUI = 3'b100,
    ALU_JAL = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    pc_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jal;
    logic    jalr;
  } ctrl_t;

  function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] instr);
    case (t)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass from the single writeback port; x0 is hardwired to zero.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [XLEN-1:0]         wr_data
);

  logic [XLEN-1:0] regs [NREG];
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A value being written back this cycle is visible to the decode in the same cycle
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (wr_live && wr_addr == rs1_addr) rs1_data = wr_data;
    if (wr_live && wr_addr == rs2_addr) rs2_data = wr_data;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: control decode, immediate generation,
// register read, load-use stall detection and the ID/EX pipeline register.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] IF_pc_out,
  input  logic [31:0]     IF_instr_out,
  input  logic            ID_Flush,
  input  logic            EX_MemRead,
  input  logic [4:0]      EX_rd,
  input  logic            WB_RegWrite,
  input  logic [4:0]      WB_rd,
  input  logic [XLEN-1:0] WB_data,
  output logic            PCWrite,
  output logic            IFID_RegWrite,
  output logic [XLEN-1:0] ID_pc,
  output logic [XLEN-1:0] ID_rs1_data,
  output logic [XLEN-1:0] ID_rs2_data,
  output logic [XLEN-1:0] ID_imm,
  output logic [4:0]      ID_rs1_addr,
  output logic [4:0]      ID_rs2_addr,
  output logic [4:0]      ID_rd,
  output logic [2:0]      ID_funct3,
  output logic            ID_funct7b5,
  output logic [2:0]      ID_ALUOp,
  output logic            ID_ALUSrc,
  output logic            ID_PCtoReg,
  output logic            ID_RegWrite,
  output logic            ID_MemRead,
  output logic            ID_MemWrite,
  output logic            ID_MemtoReg,
  output logic            ID_Branch,
  output logic            ID_Jal,
  output logic            ID_Jalr
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data;
  ctrl_t           ctrl, ctrl_next;
  imm_type_e       imm_type;
  logic            uses_rs1, uses_rs2, stall;

  assign opcode = IF_instr_out[6:0];
  assign rd     = IF_instr_out[11:7];
  assign rs1    = IF_instr_out[19:15];
  assign rs2    = IF_instr_out[24:20];

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (WB_RegWrite),
    .wr_addr  (WB_rd),
    .wr_data  (WB_data)
  );

  always_comb begin
    ctrl     = '0;
    imm_type = IMM_NONE;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_R;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_I;
        imm_type = IMM_I; uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
        ctrl.mem_to_reg = 1'b1; ctrl.alu_op = ALU_ADD;
        imm_type = IMM_I; uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu_op = ALU_ADD;
        imm_type = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1; ctrl.alu_op = ALU_BR;
        imm_type = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1; ctrl.jal = 1'b1; ctrl.pc_to_reg = 1'b1; ctrl.alu_op = ALU_JAL;
        imm_type = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1; ctrl.jalr = 1'b1; ctrl.pc_to_reg = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
        imm_type = IMM_I; uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_LUI;
        imm_type = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.pc_to_reg = 1'b1; ctrl.alu_op = ALU_ADD;
        imm_type = IMM_U;
      end
      default: ;
    endcase
  end

  // Load-use: the consumer waits one cycle; a flush makes the wait pointless
  assign stall = EX_MemRead && (EX_rd != 5'd0) &&
                 ((uses_rs1 && EX_rd == rs1) || (uses_rs2 && EX_rd == rs2));
  assign PCWrite       = !stall || ID_Flush;
  assign IFID_RegWrite = !stall || ID_Flush;
  assign ctrl_next     = (stall || ID_Flush) ? ctrl_t'('0) : ctrl;

  // ID/EX boundary
  ctrl_t           ctrl_p1;
  logic [XLEN-1:0] pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
  logic [4:0]      rs1_p1, rs2_p1, rd_p1;
  logic [2:0]      funct3_p1;
  logic            funct7b5_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_p1     <= '0;
      pc_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      funct3_p1   <= '0;
      funct7b5_p1 <= 1'b0;
    end else begin
      ctrl_p1     <= ctrl_next;
      pc_p1       <= IF_pc_out;
      rs1_data_p1 <= rs1_data;
      rs2_data_p1 <= rs2_data;
      imm_p1      <= gen_imm(imm_type, IF_instr_out);
      rs1_p1      <= rs1;
      rs2_p1      <= rs2;
      rd_p1       <= rd;
      funct3_p1   <= IF_instr_out[14:12];
      funct7b5_p1 <= IF_instr_out[30];
    end
  end

  assign ID_pc       = pc_p1;
  assign ID_rs1_data = rs1_data_p1;
  assign ID_rs2_data = rs2_data_p1;
  assign ID_imm      = imm_p1;
  assign ID_rs1_addr = rs1_p1;
  assign ID_rs2_addr = rs2_p1;
  assign ID_rd       = rd_p1;
  assign ID_funct3   = funct3_p1;
  assign ID_funct7b5 = funct7b5_p1;
  assign ID_ALUOp    = ctrl_p1.alu_op;
  assign ID_ALUSrc   = ctrl_p1.alu_src;
  assign ID_PCtoReg  = ctrl_p1.pc_to_reg;
  assign ID_RegWrite = ctrl_p1.reg_write;
  assign ID_MemRead  = ctrl_p1.mem_read;
  assign ID_MemWrite = ctrl_p1.mem_write;
  assign ID_MemtoReg = ctrl_p1.mem_to_reg;
  assign ID_Branch   = ctrl_p1.branch;
  assign ID_Jal      = ctrl_p1.jal;
  assign ID_Jalr     = ctrl_p1.jalr;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a driver issues directed and random decode
// cycles and queues the reference-model result; a monitor checks each ID/EX update.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_pc_out, IF_instr_out, WB_data;
  logic        ID_Flush, EX_MemRead, WB_RegWrite;
  logic [4:0]  EX_rd, WB_rd;
  logic        PCWrite, IFID_RegWrite;
  logic [31:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imm;
  logic [4:0]  ID_rs1_addr, ID_rs2_addr, ID_rd;
  logic [2:0]  ID_funct3, ID_ALUOp;
  logic        ID_funct7b5, ID_ALUSrc, ID_PCtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite;
  logic        ID_MemtoReg, ID_Branch, ID_Jal, ID_Jalr;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst(rst), .IF_pc_out(IF_pc_out), .IF_instr_out(IF_instr_out),
    .ID_Flush(ID_Flush), .EX_MemRead(EX_MemRead), .EX_rd(EX_rd),
    .WB_RegWrite(WB_RegWrite), .WB_rd(WB_rd), .WB_data(WB_data),
    .PCWrite(PCWrite), .IFID_RegWrite(IFID_RegWrite),
    .ID_pc(ID_pc), .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imm(ID_imm),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr), .ID_rd(ID_rd),
    .ID_funct3(ID_funct3), .ID_funct7b5(ID_funct7b5), .ID_ALUOp(ID_ALUOp),
    .ID_ALUSrc(ID_ALUSrc), .ID_PCtoReg(ID_PCtoReg), .ID_RegWrite(ID_RegWrite),
    .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg),
    .ID_Branch(ID_Branch), .ID_Jal(ID_Jal), .ID_Jalr(ID_Jalr)
  );

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [11:0] ctrl;
    logic        pcw;
    logic        dc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mregs [32];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'd1 << (bits - 1);
    return (v ^ m) - m;
  endfunction

  function automatic logic [11:0] dut_ctrl();
    return {ID_ALUOp, ID_ALUSrc, ID_PCtoReg, ID_RegWrite, ID_MemRead, ID_MemWrite,
            ID_MemtoReg, ID_Branch, ID_Jal, ID_Jalr};
  endfunction

  // Reference: per-opcode control word {ALUOp, ALUSrc, PCtoReg, RegWrite, MemRead,
  // MemWrite, MemtoReg, Branch, Jal, Jalr}, operand usage, and immediate bit-gathering.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                       input logic exmr, input logic [4:0] exrd, input logic wbwe,
                       input logic [4:0] wbrd, input logic [31:0] wbd);
    exp_t e;
    logic u1, u2, stall;
    logic [11:0] c;
    logic [31:0] imm;
    logic [4:0] r1, r2;
    @(negedge clk);
    IF_instr_out = instr; IF_pc_out = pc; ID_Flush = flush; EX_MemRead = exmr;
    EX_rd = exrd; WB_RegWrite = wbwe; WB_rd = wbrd; WB_data = wbd;
    if (wbwe && wbrd != 0) mregs[wbrd] = wbd;
    r1 = instr[19:15]; r2 = instr[24:20];
    u1 = 0; u2 = 0; c = '0; imm = 0;
    case (instr[6:0])
      7'h33: begin c = 12'b000_001000000; u1 = 1; u2 = 1; end
      7'h13: begin c = 12'b001_101000000; u1 = 1; imm = sx(instr >> 20, 12); end
      7'h03: begin c = 12'b010_101101000; u1 = 1; imm = sx(instr >> 20, 12); end
      7'h23: begin c = 12'b010_100010000; u1 = 1; u2 = 1;
                   imm = sx(((instr >> 25) << 5) | ((instr >> 7) & 31), 12); end
      7'h63: begin c = 12'b011_000000100; u1 = 1; u2 = 1;
                   imm = sx(((instr >> 31) << 12) | (((instr >> 7) & 1) << 11) |
                            (((instr >> 25) & 63) << 5) | (((instr >> 8) & 15) << 1), 13); end
      7'h6F: begin c = 12'b101_011000010;
                   imm = sx(((instr >> 31) << 20) | (((instr >> 12) & 255) << 12) |
                            (((instr >> 20) & 1) << 11) | (((instr >> 21) & 1023) << 1), 21); end
      7'h67: begin c = 12'b010_111000001; u1 = 1; imm = sx(instr >> 20, 12); end
      7'h37: begin c = 12'b100_101000000; imm = instr & 32'hFFFFF000; end
      7'h17: begin c = 12'b010_111000000; imm = instr & 32'hFFFFF000; end
      default: ;
    endcase
    stall  = exmr && exrd != 0 && ((u1 && exrd == r1) || (u2 && exrd == r2));
    e.pcw  = !stall || flush;
    e.dc   = stall || flush;
    e.ctrl = e.dc ? 12'b0 : c;
    e.pc   = pc; e.imm = imm; e.rs1a = r1; e.rs2a = r2; e.rd = instr[11:7];
    e.f3   = instr[14:12]; e.f7 = instr[30];
    e.rs1d = (r1 == 0) ? 32'b0 : mregs[r1];
    e.rs2d = (r2 == 0) ? 32'b0 : mregs[r2];
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        mon_e = q.pop_front();
        chk("pcwrite", {31'b0, PCWrite}, {31'b0, mon_e.pcw});
        chk("ifid_regwrite", {31'b0, IFID_RegWrite}, {31'b0, mon_e.pcw});
        chk("ctrl", {20'b0, dut_ctrl()}, {20'b0, mon_e.ctrl});
        if (!mon_e.dc) begin
          chk("pc", ID_pc, mon_e.pc);
          chk("imm", ID_imm, mon_e.imm);
          chk("rs1_data", ID_rs1_data, mon_e.rs1d);
          chk("rs2_data", ID_rs2_data, mon_e.rs2d);
          chk("fields", {12'b0, ID_rs1_addr, ID_rs2_addr, ID_rd, ID_funct3, ID_funct7b5},
              {12'b0, mon_e.rs1a, mon_e.rs2a, mon_e.rd, mon_e.f3, mon_e.f7});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam logic [31:0] SUB_X6 = 32'h40728333;
  localparam logic [31:0] LW_OPS [4] = '{32'h00500093, 32'h002101B3, 32'h00000233, 32'hABCDE0B7};
  localparam logic [6:0]  OPS [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                                      7'h37, 7'h17, 7'h00, 7'h7F};

  initial begin
    logic [31:0] instr;
    logic [4:0]  exrd, wbrd;
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    rst = 1; IF_pc_out = 0; IF_instr_out = 0; ID_Flush = 0; EX_MemRead = 0;
    EX_rd = 0; WB_RegWrite = 0; WB_rd = 0; WB_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {20'b0, dut_ctrl()}, 32'b0);
    chk("reset_pc_imm", ID_pc | ID_imm | ID_rs1_data | ID_rs2_data, 32'b0);
    chk("reset_pcwrite", {30'b0, PCWrite, IFID_RegWrite}, 32'd3);
    rst = 0;

    // Directed decode, bypass, stall and immediate cases
    drive(LW_OPS[0], 32'h100, 0, 0, 0, 0, 0, 0);                     // addi x1,x0,5
    drive(LW_OPS[1], 32'h104, 0, 0, 0, 1, 2, 32'hDEADBEEF);          // add x3,x2,x2 with bypass
    drive(LW_OPS[2], 32'h108, 0, 0, 0, 1, 0, 32'h12345678);          // x0 write ignored
    drive(LW_OPS[1], 32'h10C, 0, 0, 0, 0, 0, 0);                     // x2 now from storage
    drive(SUB_X6, 32'h110, 0, 1, 5, 0, 0, 0);                        // load-use stall
    drive(SUB_X6, 32'h110, 0, 1, 0, 0, 0, 0);                        // EX_rd = 0, no stall
    drive(SUB_X6, 32'h114, 1, 1, 5, 0, 0, 0);                        // flush over stall
    drive(32'hFE000CE3, 32'h118, 0, 0, 0, 0, 0, 0);                  // beq -8
    drive(32'h001000EF, 32'h11C, 0, 0, 0, 0, 0, 0);                  // jal 2048
    drive(LW_OPS[3], 32'h120, 0, 0, 0, 0, 0, 0);                     // lui
    drive(32'hFE20AE23, 32'h124, 0, 0, 0, 0, 0, 0);                  // sw -4

    // Random mix of opcodes, writebacks, hazards and flushes
    for (int n = 0; n < 400; n++) begin
      instr = $urandom;
      instr[6:0] = OPS[$urandom_range(0, 10)];
      if ($urandom_range(0, 15) == 0) instr = 0;
      case ($urandom_range(0, 3))
        0: exrd = instr[19:15];
        1: exrd = instr[24:20];
        default: exrd = 5'($urandom);
      endcase
      wbrd = ($urandom_range(0, 2) == 0) ? instr[19:15] : 5'($urandom);
      drive(instr, $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, exrd,
            $urandom_range(0, 1) == 1, wbrd, $urandom);
    end

    // Asynchronous reset in the middle of a stall
    drive(LW_OPS[3], 32'h200, 0, 0, 0, 1, 2, 32'hCAFEF00D);
    @(negedge clk);
    IF_instr_out = SUB_X6; EX_MemRead = 1; EX_rd = 5; ID_Flush = 0; WB_RegWrite = 0;
    #1;
    chk("midstall_pcwrite", {30'b0, PCWrite, IFID_RegWrite}, 32'd0);
    #1 rst = 1;
    #1;
    chk("async_rst_ctrl", {20'b0, dut_ctrl()}, 32'b0);
    chk("async_rst_data", ID_pc | ID_imm | ID_rs1_data | ID_rs2_data, 32'b0);
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    @(negedge clk);
    rst = 0; EX_MemRead = 0;
    drive(LW_OPS[1], 32'h300, 0, 0, 0, 0, 0, 0);                     // x2 cleared by reset
    drive(LW_OPS[0], 32'h304, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
